// File: rtl/ctrl_registrodesp_pkg.sv
// Shared encodings for the shift-register sequencing controller:
// register modes, FSM states, command op codes and the latched command record.
package ctrl_registrodesp_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_TX   = 3'd2,
    ST_RX   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  localparam logic OP_TX = 1'b0;
  localparam logic OP_RX = 1'b1;

  // dir is stored already mapped to the register's sense (1 = toward MSB).
  typedef struct packed {
    logic       op;
    logic       dir;
    logic [3:0] data;
  } cmd_t;

endpackage

// File: rtl/ctrl_registrodesp_if.sv
// Command/response handshakes, serial streams and shift-register control bundle.
// master = controller side, slave = environment (producer/consumer and register).
interface ctrl_registrodesp_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic       cmd_lsb_first;
  logic [3:0] cmd_data;
  logic       ser_out;
  logic       ser_out_valid;
  logic       ser_in;
  logic       ser_in_valid;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       reg_enb;
  logic       reg_dir;
  logic       reg_s_in;
  logic [1:0] reg_mode;
  logic [3:0] reg_d;
  logic [3:0] reg_q;
  logic       reg_s_out;

  modport master (
    input  cmd_valid, cmd_op, cmd_lsb_first, cmd_data,
    input  ser_in, ser_in_valid, rsp_ready, reg_q, reg_s_out,
    output cmd_ready, ser_out, ser_out_valid, rsp_valid, rsp_data,
    output reg_enb, reg_dir, reg_s_in, reg_mode, reg_d
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_lsb_first, cmd_data,
    output ser_in, ser_in_valid, rsp_ready, reg_q, reg_s_out,
    input  cmd_ready, ser_out, ser_out_valid, rsp_valid, rsp_data,
    input  reg_enb, reg_dir, reg_s_in, reg_mode, reg_d
  );

endinterface

// File: rtl/ctrl_registrodesp_div_counter.sv
// Bit-period divider: tick marks the last of every DIV enabled cycles.
// Zero latency on tick; clr restarts the period, no backpressure.
module div_counter #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_L,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/ctrl_registrodesp.sv
// Sequences a 4-bit shift register to serialize (TX) or deserialize (RX) one word per command.
// TX: 1 load cycle + 4*DIV bit cycles; RX stalls on ser_in_valid=0; RESP holds until rsp_ready.
module ctrl_registrodesp
  import ctrl_registrodesp_pkg::*;
#(
  parameter int DIV = 1
) (
  input logic                 clk,
  input logic                 reset_L,
  ctrl_registrodesp_if.master bus
);

  state_e     state;
  cmd_t       cmd_q;
  logic [1:0] bit_cnt;
  logic       cmd_ready_q;
  logic       ser_vld_q;
  logic       rsp_vld_q;
  logic       tick;
  logic       last_bit;

  assign last_bit = (bit_cnt == 2'd3);

  // Divider runs only in TX; holding it cleared elsewhere restarts it on every LOAD.
  div_counter #(.DIV(DIV)) u_div (
    .clk    (clk),
    .reset_L(reset_L),
    .clr    (state != ST_TX),
    .en     (state == ST_TX),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      bit_cnt     <= '0;
      cmd_ready_q <= 1'b1;
      ser_vld_q   <= 1'b0;
      rsp_vld_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_q       <= '{op: bus.cmd_op, dir: ~bus.cmd_lsb_first, data: bus.cmd_data};
            bit_cnt     <= '0;
            cmd_ready_q <= 1'b0;
            state       <= (bus.cmd_op == OP_TX) ? ST_LOAD : ST_RX;
          end
        end
        ST_LOAD: begin
          state     <= ST_TX;
          ser_vld_q <= 1'b1;
        end
        ST_TX: begin
          if (tick) begin
            bit_cnt <= bit_cnt + 2'd1;
            if (last_bit) begin
              state       <= ST_IDLE;
              ser_vld_q   <= 1'b0;
              cmd_ready_q <= 1'b1;
            end
          end
        end
        ST_RX: begin
          if (bus.ser_in_valid) begin
            bit_cnt <= bit_cnt + 2'd1;
            if (last_bit) begin
              state     <= ST_RESP;
              rsp_vld_q <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state       <= ST_IDLE;
            rsp_vld_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          ser_vld_q   <= 1'b0;
          rsp_vld_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.reg_enb  = 1'b0;
    bus.reg_mode = MODE_HOLD;
    bus.reg_d    = '0;
    bus.reg_s_in = 1'b0;
    case (state)
      ST_LOAD: begin
        bus.reg_enb  = 1'b1;
        bus.reg_mode = MODE_LOAD;
        bus.reg_d    = cmd_q.data;
      end
      ST_TX: begin
        if (tick) begin
          bus.reg_enb  = 1'b1;
          bus.reg_mode = MODE_SHIFT;
        end
      end
      ST_RX: begin
        if (bus.ser_in_valid) begin
          bus.reg_enb  = 1'b1;
          bus.reg_mode = MODE_SHIFT;
          bus.reg_s_in = bus.ser_in;
        end
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.ser_out_valid = ser_vld_q;
  // Gated so the stream reads 0 whenever it is not being driven.
  assign bus.ser_out       = ser_vld_q & bus.reg_s_out;
  assign bus.rsp_valid     = rsp_vld_q;
  assign bus.rsp_data      = bus.reg_q;
  assign bus.reg_dir       = cmd_q.dir;

endmodule

// File: tb/tb_ctrl_registrodesp.sv
// Bench for ctrl_registrodesp: DIV=1 and DIV=3 instances share stimulus, each driving its own
// behavioural 4-bit shift register; directed vector table plus reset/abort sequences.
module tb_ctrl_registrodesp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_L;
  logic       cmd_valid, cmd_op, cmd_lsb_first;
  logic [3:0] cmd_data;
  logic       ser_in, ser_in_valid, rsp_ready;
  logic       sel;
  int         n_tests = 0;
  int         n_fail  = 0;

  ctrl_registrodesp_if b1 ();
  ctrl_registrodesp_if b3 ();

  ctrl_registrodesp #(.DIV(1)) dut1 (.clk(clk), .reset_L(reset_L), .bus(b1));
  ctrl_registrodesp #(.DIV(3)) dut3 (.clk(clk), .reset_L(reset_L), .bus(b3));

  assign b1.cmd_valid = cmd_valid;         assign b3.cmd_valid = cmd_valid;
  assign b1.cmd_op = cmd_op;               assign b3.cmd_op = cmd_op;
  assign b1.cmd_lsb_first = cmd_lsb_first; assign b3.cmd_lsb_first = cmd_lsb_first;
  assign b1.cmd_data = cmd_data;           assign b3.cmd_data = cmd_data;
  assign b1.ser_in = ser_in;               assign b3.ser_in = ser_in;
  assign b1.ser_in_valid = ser_in_valid;   assign b3.ser_in_valid = ser_in_valid;
  assign b1.rsp_ready = rsp_ready;         assign b3.rsp_ready = rsp_ready;

  // Shift register behaviour as seen by the controller (no reset).
  function automatic logic [3:0] reg_next(input logic [3:0] q, input logic [1:0] mode,
                                          input logic dir, input logic s_in, input logic [3:0] d);
    case (mode)
      2'b00:   return dir ? {q[2:0], s_in} : {s_in, q[3:1]};
      2'b01:   return dir ? {q[2:0], q[3]} : {q[0], q[3:1]};
      2'b10:   return d;
      default: return q;
    endcase
  endfunction

  logic [3:0] q1 = 4'h0;
  logic [3:0] q3 = 4'h0;
  always @(posedge clk) if (b1.reg_enb) q1 <= reg_next(q1, b1.reg_mode, b1.reg_dir, b1.reg_s_in, b1.reg_d);
  always @(posedge clk) if (b3.reg_enb) q3 <= reg_next(q3, b3.reg_mode, b3.reg_dir, b3.reg_s_in, b3.reg_d);
  assign b1.reg_q = q1;
  assign b3.reg_q = q3;
  assign b1.reg_s_out = b1.reg_dir ? q1[3] : q1[0];
  assign b3.reg_s_out = b3.reg_dir ? q3[3] : q3[0];

  typedef struct packed {
    logic       cmd_ready, ser_out, ser_out_valid, rsp_valid;
    logic [3:0] rsp_data;
    logic       reg_enb, reg_dir, reg_s_in;
    logic [1:0] reg_mode;
    logic [3:0] reg_d;
  } obs_t;

  obs_t o1, o3, o;
  assign o1 = {b1.cmd_ready, b1.ser_out, b1.ser_out_valid, b1.rsp_valid, b1.rsp_data,
               b1.reg_enb, b1.reg_dir, b1.reg_s_in, b1.reg_mode, b1.reg_d};
  assign o3 = {b3.cmd_ready, b3.ser_out, b3.ser_out_valid, b3.rsp_valid, b3.rsp_data,
               b3.reg_enb, b3.reg_dir, b3.reg_s_in, b3.reg_mode, b3.reg_d};
  assign o  = sel ? o3 : o1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ready"},  o.cmd_ready,     1);
    chk({nm, "_sovld"},  o.ser_out_valid, 0);
    chk({nm, "_sout"},   o.ser_out,       0);
    chk({nm, "_rspvld"}, o.rsp_valid,     0);
    chk({nm, "_enb"},    o.reg_enb,       0);
    chk({nm, "_mode"},   o.reg_mode,      2'b11);
    chk({nm, "_dir"},    o.reg_dir,       0);
    chk({nm, "_sin"},    o.reg_s_in,      0);
    chk({nm, "_d"},      o.reg_d,         0);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(o1.cmd_ready && o3.cmd_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", {31'd0, o1.cmd_ready & o3.cmd_ready}, 1);
  endtask

  // exp_seq[3] is the first bit expected on ser_out; exp_period counts the accept cycle.
  task automatic run_tx(input bit s, input bit lsb, input logic [3:0] data, input logic [3:0] exp_seq,
                        input int exp_period, input bit noise, input string nm);
    int div, cycles, idx, nvld;
    div = s ? 3 : 1;
    wait_idle();
    sel = s;
    ser_in_valid = noise; ser_in = noise;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_lsb_first = lsb; cmd_data = data;
    #1;
    chk({nm, "_acc_ready"}, o.cmd_ready, 1);
    chk({nm, "_acc_enb"},   o.reg_enb,   0);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = 4'h0;
    cycles = 2;
    #1;
    chk({nm, "_ld_enb"},  o.reg_enb,       1);
    chk({nm, "_ld_mode"}, o.reg_mode,      2'b10);
    chk({nm, "_ld_d"},    o.reg_d,         data);
    chk({nm, "_ld_dir"},  o.reg_dir,       !lsb);
    chk({nm, "_ld_vld"},  o.ser_out_valid, 0);
    nvld = 0;
    while (cycles < 200) begin
      @(negedge clk);
      #1;
      if (o.cmd_ready) break;
      cycles++;
      idx = cycles - 3;
      if (o.ser_out_valid) nvld++;
      if (idx < 4 * div) begin
        chk({nm, "_bit"},  o.ser_out,  exp_seq[3 - idx / div]);
        chk({nm, "_enb"},  o.reg_enb,  (idx % div) == div - 1);
        chk({nm, "_mode"}, o.reg_mode, ((idx % div) == div - 1) ? 2'b00 : 2'b11);
        chk({nm, "_sin"},  o.reg_s_in, 0);
      end
    end
    ser_in_valid = 1'b0; ser_in = 1'b0;
    chk({nm, "_period"}, cycles,          exp_period);
    chk({nm, "_nvld"},   nvld,            4 * div);
    chk({nm, "_endvld"}, o.ser_out_valid, 0);
  endtask

  // bits[3] is sent first; gaps[7:6] idle cycles precede the first bit, gaps[1:0] the last.
  task automatic run_rx(input bit s, input bit lsb, input logic [3:0] bits, input logic [7:0] gaps,
                        input int hold, input bit poke, input logic [3:0] exp, input string nm);
    int ng;
    wait_idle();
    sel = s;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_lsb_first = lsb; cmd_data = 4'hF;
    #1;
    chk({nm, "_acc_ready"}, o.cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk({nm, "_dir"},   o.reg_dir,       !lsb);
    chk({nm, "_sovld"}, o.ser_out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      ng = int'(gaps[7 - 2 * i -: 2]);
      for (int g = 0; g < ng; g++) begin
        ser_in_valid = 1'b0; ser_in = 1'b1;
        #1;
        chk({nm, "_gap_enb"}, o.reg_enb,  0);
        chk({nm, "_gap_sin"}, o.reg_s_in, 0);
        @(negedge clk);
      end
      ser_in_valid = 1'b1; ser_in = bits[3 - i];
      #1;
      chk({nm, "_bit_enb"},  o.reg_enb,   1);
      chk({nm, "_bit_mode"}, o.reg_mode,  2'b00);
      chk({nm, "_bit_sin"},  o.reg_s_in,  bits[3 - i]);
      chk({nm, "_early"},    o.rsp_valid, 0);
      @(negedge clk);
    end
    ser_in_valid = 1'b0; ser_in = 1'b0;
    #1;
    chk({nm, "_rspvld"}, o.rsp_valid, 1);
    chk({nm, "_rsp"},    o.rsp_data,  exp);
    chk({nm, "_busy"},   o.cmd_ready, 0);
    for (int h = 0; h < hold; h++) begin
      cmd_valid = poke; cmd_op = 1'b0;
      @(negedge clk);
      #1;
      chk({nm, "_hold_vld"},   o.rsp_valid, 1);
      chk({nm, "_hold_rsp"},   o.rsp_data,  exp);
      chk({nm, "_hold_ready"}, o.cmd_ready, 0);
      chk({nm, "_hold_enb"},   o.reg_enb,   0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk({nm, "_done_ready"}, o.cmd_ready,     1);
    chk({nm, "_done_vld"},   o.rsp_valid,     0);
    chk({nm, "_done_sovld"}, o.ser_out_valid, 0);
  endtask

  typedef struct {
    bit         is_rx;
    bit         s;
    bit         lsb;
    logic [3:0] data;
    logic [7:0] gaps;
    int         hold;
    bit         extra;
    logic [3:0] exp;
    int         period;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // TX: exp = serial order, MSB of exp first. RX: data = bits in send order.
    vecs[0] = '{is_rx: 0, s: 0, lsb: 0, data: 4'b1011, gaps: 8'h00, hold: 0, extra: 0, exp: 4'b1011, period: 6};
    vecs[1] = '{is_rx: 0, s: 1, lsb: 1, data: 4'b0110, gaps: 8'h00, hold: 0, extra: 0, exp: 4'b0110, period: 14};
    vecs[2] = '{is_rx: 0, s: 0, lsb: 1, data: 4'b1000, gaps: 8'h00, hold: 0, extra: 1, exp: 4'b0001, period: 6};
    vecs[3] = '{is_rx: 0, s: 1, lsb: 0, data: 4'b1100, gaps: 8'h00, hold: 0, extra: 1, exp: 4'b1100, period: 14};
    vecs[4] = '{is_rx: 1, s: 0, lsb: 0, data: 4'b1101, gaps: 8'b00_10_01_00, hold: 3, extra: 0, exp: 4'b1101, period: 0};
    vecs[5] = '{is_rx: 1, s: 0, lsb: 1, data: 4'b1000, gaps: 8'h00, hold: 2, extra: 1, exp: 4'b0001, period: 0};
    vecs[6] = '{is_rx: 1, s: 1, lsb: 1, data: 4'b1100, gaps: 8'b01_01_01_01, hold: 0, extra: 0, exp: 4'b0011, period: 0};
    vecs[7] = '{is_rx: 1, s: 1, lsb: 0, data: 4'b0010, gaps: 8'b11_00_00_00, hold: 1, extra: 0, exp: 4'b0010, period: 0};

    reset_L = 1'b0;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_lsb_first = 1'b0; cmd_data = 4'h0;
    ser_in = 1'b0; ser_in_valid = 1'b0; rsp_ready = 1'b0; sel = 1'b0;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk_reset("reset");
      chk("reset_rspdata", o.rsp_data, 4'h0);
    end
    @(negedge clk);
    reset_L = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_rx)
        run_rx(vecs[i].s, vecs[i].lsb, vecs[i].data, vecs[i].gaps, vecs[i].hold, vecs[i].extra,
               vecs[i].exp, $sformatf("v%0d_rx", i));
      else
        run_tx(vecs[i].s, vecs[i].lsb, vecs[i].data, vecs[i].exp, vecs[i].period, vecs[i].extra,
               $sformatf("v%0d_tx", i));
    end

    // Abort a DIV=3 MSB-first TX after two bits with an asynchronous reset.
    wait_idle();
    sel = 1'b1;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_lsb_first = 1'b0; cmd_data = 4'b1011;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    chk("abort_pre_vld", o.ser_out_valid, 1);
    chk("abort_pre_dir", o.reg_dir,       1);
    reset_L = 1'b0;
    #1;
    chk_reset("abort");
    @(negedge clk);
    reset_L = 1'b1;
    run_tx(1'b1, 1'b0, 4'b0101, 4'b0101, 14, 1'b0, "post_abort_tx");

    // ser_in_valid and rsp_ready while idle must not disturb anything.
    wait_idle();
    ser_in_valid = 1'b1; ser_in = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("idle_noise_enb", o.reg_enb,   0);
    chk("idle_noise_sin", o.reg_s_in,  0);
    @(negedge clk);
    #1;
    chk("idle_noise_ready",  o.cmd_ready, 1);
    chk("idle_noise_rspvld", o.rsp_valid, 0);
    ser_in_valid = 1'b0; ser_in = 1'b0; rsp_ready = 1'b0;
    run_rx(1'b0, 1'b0, 4'b0111, 8'h00, 0, 1'b0, 4'b0111, "post_noise_rx");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
